// File: rtl/tetris_grid_scheduler_pkg.sv
// Shared definitions for the grid scheduler and the renderer: board geometry,
// scheduler FSM encoding, display colours and a row-scan helper.
package tetris_pkg;

  localparam int GRID_ROWS = 20;
  localparam int GRID_COLS = 10;
  localparam int GRID_W    = GRID_ROWS * GRID_COLS;

  // Scheduler states: shadow in sync, shadow ahead of outputs, copying out.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } sched_state_t;

  // 12-bit RGB colours used by the renderer for each plane.
  localparam logic [11:0] COLOR_BG      = 12'h000;
  localparam logic [11:0] COLOR_STACK   = 12'h00F;
  localparam logic [11:0] COLOR_PIECE   = 12'hF00;
  localparam logic [11:0] COLOR_OVERLAP = 12'hF0F;

  // Row index reported when two planes do not overlap anywhere.
  localparam logic [4:0] NO_ROW = 5'd31;

  // Lowest-numbered row whose hit flag is set, or NO_ROW when none is.
  function automatic logic [4:0] first_row(input logic [GRID_ROWS-1:0] hit);
    logic [4:0] row;
    row = NO_ROW;
    for (int r = GRID_ROWS - 1; r >= 0; r--) begin
      if (hit[r]) row = 5'(r);
    end
    return row;
  endfunction

endpackage

// File: rtl/tetris_grid_scheduler_vsync_edge.sv
// Brings the display VSync into the clk domain and turns its falling edge
// into a single-cycle frame_tick. The tick is registered, so it appears
// SYNC_STAGES+1 clock edges after the first edge that sees vsync low.
module tetris_vsync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic frame_tick
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic                   tick_reg;
  logic                   synced;

  assign synced = sync_reg[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      logic d_in;
      if (gi == 0) begin : g_first
        assign d_in = vsync;
      end else begin : g_rest
        assign d_in = sync_reg[gi-1];
      end
      // One synchroniser stage; resets to the inactive (high) level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_reg[gi] <= 1'b1;
        else        sync_reg[gi] <= d_in;
      end
    end
  endgenerate

  // History flop plus registered falling-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg <= 1'b1;
      tick_reg <= 1'b0;
    end else begin
      hist_reg <= synced;
      tick_reg <= hist_reg & ~synced;
    end
  end

  assign frame_tick = tick_reg;

endmodule

// File: rtl/tetris_grid_scheduler.sv
// Frame-synchronous grid scheduler: round-robin arbitration of the stack (A)
// and piece (B) writers into shadow grids, copied to the renderer-facing
// grids only on a frame boundary so a frame never shows a half-updated board.
// Optional overlap reporting is enabled with `define TETRIS_COLLISION_DETECT_EN.
module tetris_grid_scheduler
  import tetris_pkg::*;
#(
  parameter int GRID_W      = tetris_pkg::GRID_W,
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_DIV   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              req_a,
  input  logic [GRID_W-1:0] data_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [GRID_W-1:0] data_b,
  output logic              ack_b,
  output logic [GRID_W-1:0] grid_a,
  output logic [GRID_W-1:0] grid_b,
  output logic              frame_tick,
  output logic              commit,
  output logic              pending
`ifdef TETRIS_COLLISION_DETECT_EN
  ,
  output logic              collision,
  output logic [4:0]        collision_row
`endif
);

  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);

  sched_state_t      state_reg, state_next;
  logic [3:0]        div_cnt_reg;
  logic              ack_a_reg, ack_b_reg;
  logic              ptr_b_reg;      // 0: A wins a tie, 1: B wins a tie
  logic [GRID_W-1:0] shadow_a_reg, shadow_b_reg;
  logic [GRID_W-1:0] grid_a_reg, grid_b_reg;
  logic              boundary;
  logic              commit_now;
  logic              grant_a, grant_b;
  logic              cand_a, cand_b;

  tetris_vsync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_vsync_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync     (vsync),
    .frame_tick(frame_tick)
  );

  assign boundary = frame_tick && (div_cnt_reg == DIV_LAST);

  // Frame divider: counts every tick, whatever state the FSM is in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= 4'd0;
    end else if (frame_tick) begin
      div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? 4'd0 : div_cnt_reg + 4'd1;
    end
  end

  // Arbitration and next-state. A requester still showing its ack is masked
  // so a held request is not granted twice. No grant is made on the edge that
  // enters COMMIT, which keeps ack low during the COMMIT cycle.
  always_comb begin
    state_next = state_reg;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    cand_a     = req_a & ~ack_a_reg;
    cand_b     = req_b & ~ack_b_reg;
    commit_now = (state_reg == PENDING) && boundary;

    if (!commit_now) begin
      if (cand_a && cand_b) begin
        grant_a = ~ptr_b_reg;
        grant_b = ptr_b_reg;
      end else begin
        grant_a = cand_a;
        grant_b = cand_b;
      end
    end

    case (state_reg)
      IDLE:    if (grant_a || grant_b) state_next = PENDING;
      PENDING: if (commit_now)         state_next = COMMIT;
      // A write granted on the way out of COMMIT is already uncommitted.
      COMMIT:  state_next = (grant_a || grant_b) ? PENDING : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state, ack pulses and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ack_a_reg <= 1'b0;
      ack_b_reg <= 1'b0;
      ptr_b_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_a_reg <= grant_a;
      ack_b_reg <= grant_b;
      if (grant_a)      ptr_b_reg <= 1'b1;
      else if (grant_b) ptr_b_reg <= 1'b0;
    end
  end

  // Shadow capture on grant (last writer wins) and copy-out on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_a_reg <= '0;
      shadow_b_reg <= '0;
      grid_a_reg   <= '0;
      grid_b_reg   <= '0;
    end else begin
      if (grant_a) shadow_a_reg <= data_a;
      if (grant_b) shadow_b_reg <= data_b;
      if (commit_now) begin
        grid_a_reg <= shadow_a_reg;
        grid_b_reg <= shadow_b_reg;
      end
    end
  end

  assign ack_a   = ack_a_reg;
  assign ack_b   = ack_b_reg;
  assign grid_a  = grid_a_reg;
  assign grid_b  = grid_b_reg;
  assign commit  = (state_reg == COMMIT);
  assign pending = (state_reg == PENDING);

`ifdef TETRIS_COLLISION_DETECT_EN
  logic [GRID_ROWS-1:0] row_hit;
  logic                 collision_reg;
  logic [4:0]           collision_row_reg;

  genvar gi;
  generate
    for (gi = 0; gi < GRID_ROWS; gi++) begin : g_row
      // Row gi occupies the gi-th group of GRID_COLS bits from the MSB end.
      assign row_hit[gi] = |(grid_a_reg[GRID_W-1-gi*GRID_COLS -: GRID_COLS] &
                             grid_b_reg[GRID_W-1-gi*GRID_COLS -: GRID_COLS]);
    end
  endgenerate

  // Overlap of the freshly committed grids, sampled in the COMMIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_reg     <= 1'b0;
      collision_row_reg <= NO_ROW;
    end else if (state_reg == COMMIT) begin
      collision_reg     <= |row_hit;
      collision_row_reg <= first_row(row_hit);
    end
  end

  assign collision     = collision_reg;
  assign collision_row = collision_row_reg;
`endif

endmodule
